// File: rtl/cp0_except_pkg.sv
// rtl/cp0_except_pkg.sv - CP0 register numbers, ExcCodes, field positions and commit arbitration
package cp0_except_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;

    typedef enum logic [1:0] {
        CMT_NONE,
        CMT_EXC,
        CMT_ERET,
        CMT_MTC0
    } cmt_e;

    // One committing instruction performs at most one CP0 action; exception beats ERET beats MTC0.
    function automatic cmt_e commit_sel(input logic valid, input logic exc,
                                        input logic eret, input logic we);
        cmt_e sel;
        sel = CMT_NONE;
        if (valid) begin
            if (exc)       sel = CMT_EXC;
            else if (eret) sel = CMT_ERET;
            else if (we)   sel = CMT_MTC0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cp0_except_timer.sv
// rtl/cp0_except_timer.sv - Count/Compare timer: Count advances every second cycle, TI on match
module cp0_timer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic [31:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (i_count_we)  w_count_nxt = i_wdata;
        else if (r_tick) w_count_nxt = r_count + 32'd1;
    end

    // Match is checked against the value Count takes this edge; a Compare write clears TI regardless.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick    <= 1'b0;
            r_count   <= 32'h0;
            r_compare <= 32'h0;
            r_ti      <= 1'b0;
        end else begin
            r_tick  <= ~r_tick;
            r_count <= w_count_nxt;
            if (i_compare_we) begin
                r_compare <= i_wdata;
                r_ti      <= 1'b0;
            end else if (w_count_nxt == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_except.sv
// rtl/cp0_except.sv - CP0 exception commit: Status/Cause/EPC/BadVAddr, flush/redirect, MFC0/MTC0
module cp0_except
    import cp0_except_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_valid,
    input  logic        i_wb_except,
    input  logic [4:0]  i_wb_excode,
    input  logic [31:0] i_wb_pc,
    input  logic        i_wb_in_ds,
    input  logic [31:0] i_wb_badvaddr,
    input  logic        i_wb_eret,
    input  logic        i_mtc0_we,
    input  logic [4:0]  i_cp0_waddr,
    input  logic [31:0] i_cp0_wdata,
    input  logic [4:0]  i_cp0_raddr,
    output logic [31:0] o_cp0_rdata,
    input  logic [5:0]  i_hw_int,
    output logic        o_int_req,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc
);

    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;

    cmt_e        w_cmt;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [31:0] w_cause;
    logic [7:0]  w_ip;

    // Reset masks the commit so a coincident exception neither flushes nor updates state.
    always_comb begin
        w_cmt        = commit_sel(i_wb_valid & ~i_rst, i_wb_except, i_wb_eret, i_mtc0_we);
        w_wr_count   = (w_cmt == CMT_MTC0) && (i_cp0_waddr == CP0_COUNT);
        w_wr_compare = (w_cmt == CMT_MTC0) && (i_cp0_waddr == CP0_COMPARE);
    end

    cp0_timer u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_count_we   (w_wr_count),
        .i_compare_we (w_wr_compare),
        .i_wdata      (i_cp0_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_status   <= STATUS_RST;
            r_epc      <= 32'h0;
            r_badvaddr <= 32'h0;
            r_bd       <= 1'b0;
            r_exccode  <= 5'h0;
            r_ip_hw    <= 6'h0;
            r_ip_sw    <= 2'h0;
        end else begin
            r_ip_hw <= {i_hw_int[5] | w_ti, i_hw_int[4:0]};
            case (w_cmt)
                CMT_EXC: begin
                    r_exccode        <= i_wb_excode;
                    r_status[ST_EXL] <= 1'b1;
                    // A nested exception keeps the original return point.
                    if (!r_status[ST_EXL]) begin
                        r_epc <= i_wb_in_ds ? (i_wb_pc - 32'd4) : i_wb_pc;
                        r_bd  <= i_wb_in_ds;
                    end
                    if (i_wb_excode == EXC_ADEL || i_wb_excode == EXC_ADES)
                        r_badvaddr <= i_wb_badvaddr;
                end
                CMT_ERET: r_status[ST_EXL] <= 1'b0;
                CMT_MTC0: begin
                    case (i_cp0_waddr)
                        CP0_STATUS: begin
                            r_status[15:8] <= i_cp0_wdata[15:8];
                            r_status[1:0]  <= i_cp0_wdata[1:0];
                        end
                        CP0_CAUSE: r_ip_sw <= i_cp0_wdata[9:8];
                        CP0_EPC:   r_epc   <= i_cp0_wdata;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_ip    = {r_ip_hw, r_ip_sw};
        w_cause = {r_bd, w_ti, 14'h0, w_ip, 1'b0, r_exccode, 2'b00};
    end

    always_comb begin
        o_cp0_rdata = 32'h0;
        case (i_cp0_raddr)
            CP0_BADVADDR: o_cp0_rdata = r_badvaddr;
            CP0_COUNT:    o_cp0_rdata = w_count;
            CP0_COMPARE:  o_cp0_rdata = w_compare;
            CP0_STATUS:   o_cp0_rdata = r_status;
            CP0_CAUSE:    o_cp0_rdata = w_cause;
            CP0_EPC:      o_cp0_rdata = r_epc;
            default:      o_cp0_rdata = 32'h0;
        endcase
    end

    always_comb begin
        o_flush       = 1'b0;
        o_redirect_pc = 32'h0;
        if (w_cmt == CMT_EXC) begin
            o_flush       = 1'b1;
            o_redirect_pc = EXC_VECTOR;
        end else if (w_cmt == CMT_ERET) begin
            o_flush       = 1'b1;
            o_redirect_pc = r_epc;
        end
        o_int_req = r_status[ST_IE] & ~r_status[ST_EXL] & (|(w_ip & r_status[15:8]));
    end

endmodule

// File: tb/tb_cp0_except.sv
// tb/tb_cp0_except.sv - directed bench for cp0_except with an expected-value queue
module tb_cp0_except;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_except, wb_in_ds, wb_eret, mtc0_we;
    logic [4:0]  wb_excode, cp0_waddr, cp0_raddr;
    logic [31:0] wb_pc, wb_badvaddr, cp0_wdata, cp0_rdata, redirect_pc;
    logic [5:0]  hw_int;
    logic        int_req, flush;

    always #5 clk = ~clk;

    cp0_except dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_valid(wb_valid), .i_wb_except(wb_except), .i_wb_excode(wb_excode),
        .i_wb_pc(wb_pc), .i_wb_in_ds(wb_in_ds), .i_wb_badvaddr(wb_badvaddr),
        .i_wb_eret(wb_eret), .i_mtc0_we(mtc0_we), .i_cp0_waddr(cp0_waddr),
        .i_cp0_wdata(cp0_wdata), .i_cp0_raddr(cp0_raddr), .o_cp0_rdata(cp0_rdata),
        .i_hw_int(hw_int), .o_int_req(int_req), .o_flush(flush), .o_redirect_pc(redirect_pc)
    );

    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_except = 0; wb_excode = 0; wb_pc = 0; wb_in_ds = 0;
        wb_badvaddr = 0; wb_eret = 0; mtc0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_raddr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic commit(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                          input logic ds, input logic [31:0] bva, input logic eret,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [31:0] e_redir, input string tag);
        wb_valid = 1; wb_except = exc; wb_excode = code; wb_pc = pc; wb_in_ds = ds;
        wb_badvaddr = bva; wb_eret = eret; mtc0_we = we; cp0_waddr = wa; cp0_wdata = wd;
        #1;
        expect_val({31'b0, exc | eret});
        check({tag, ".flush"}, {31'b0, flush});
        expect_val(e_redir);
        check({tag, ".redirect"}, redirect_pc);
        step();
        idle();
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd, input string tag);
        commit(0, 5'h0, 32'h0, 0, 32'h0, 0, 1, wa, wd, 32'h0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, c0, c1;
        int n;
        rst = 1; hw_int = 0; cp0_raddr = 0;
        idle();
        repeat (3) step();
        rst = 0;

        rd(12, d); expect_val(32'h0040_0000); check("rst.status", d);
        rd(13, d); expect_val(32'h0);         check("rst.cause", d);
        rd(14, d); expect_val(32'h0);         check("rst.epc", d);
        expect_val(32'h0); check("rst.flush", {31'b0, flush});
        expect_val(32'h0); check("rst.int_req", {31'b0, int_req});

        commit(1, 5'h04, 32'h8000_1000, 0, 32'h1234_5671, 0, 0, 0, 0, 32'hBFC0_0380, "adel");
        rd(14, d); expect_val(32'h8000_1000); check("adel.epc", d);
        rd(13, d); expect_val(32'h04);        check("adel.exccode", {27'b0, d[6:2]});
        rd(12, d); expect_val(32'h1);         check("adel.exl", {31'b0, d[1]});
        rd(8, d);  expect_val(32'h1234_5671); check("adel.badvaddr", d);

        mtc0(12, 32'h0, "clr_status");
        rd(12, d); expect_val(32'h0040_0000); check("status.bev_ro", d);

        commit(1, 5'h08, 32'h8000_2004, 1, 32'hFFFF_0000, 0, 0, 0, 0, 32'hBFC0_0380, "sys_ds");
        rd(14, d); expect_val(32'h8000_2000); check("sys_ds.epc", d);
        rd(13, d); expect_val(32'h1);         check("sys_ds.bd", {31'b0, d[31]});

        commit(1, 5'h0C, 32'h8000_3000, 0, 32'hFFFF_0000, 0, 0, 0, 0, 32'hBFC0_0380, "ov_nested");
        rd(14, d); expect_val(32'h8000_2000); check("ov_nested.epc", d);
        rd(13, d); expect_val(32'h8000_0030); check("ov_nested.bd_code", d & 32'h8000_007C);
        rd(8, d);  expect_val(32'h1234_5671); check("ov_nested.badvaddr", d);

        commit(0, 5'h0, 32'h8000_5000, 0, 32'h0, 1, 0, 0, 0, 32'h8000_2000, "eret");
        rd(12, d); expect_val(32'h0); check("eret.exl", {31'b0, d[1]});

        commit(1, 5'h0A, 32'h8000_4000, 0, 32'h0, 1, 1, 14, 32'hDEAD_BEEF, 32'hBFC0_0380, "eret_exc");
        rd(14, d); expect_val(32'h8000_4000); check("eret_exc.epc", d);
        rd(13, d); expect_val(32'h0A);        check("eret_exc.exccode", {27'b0, d[6:2]});
        rd(12, d); expect_val(32'h1);         check("eret_exc.exl", {31'b0, d[1]});

        commit(0, 5'h0, 32'h0, 0, 32'h0, 1, 0, 0, 0, 32'h8000_4000, "eret2");
        mtc0(14, 32'h1111_2222, "w_epc");
        mtc0(8, 32'h0, "w_badvaddr");
        rd(14, d); expect_val(32'h1111_2222); check("epc.rw", d);
        rd(8, d);  expect_val(32'h1234_5671); check("badvaddr.ro", d);
        rd(15, d); expect_val(32'h0);         check("unimpl.read", d);

        hw_int = 6'b000001;
        step();
        rd(13, d); expect_val(32'h1); check("hw_int0.ip10", {31'b0, d[10]});
        hw_int = 6'b0;

        mtc0(9, 32'h0, "w_count0");
        mtc0(11, 32'd10, "w_compare10");
        mtc0(12, 32'h0000_8001, "w_status_ie");
        n = 0;
        rd(12, d); expect_val(32'h0040_8001); check("status.ie_im7", d);
        expect_val(32'h0); check("timer.int_req_idle", {31'b0, int_req});
        for (int i = 3; i <= 30; i++) begin
            step();
            rd(13, d);
            if (d[30]) begin
                n = i;
                break;
            end
        end
        expect_val(32'h1); check("timer.ti_window", {31'b0, (n >= 19 && n <= 20)});
        rd(9, d); expect_val(32'd10); check("timer.count_at_ti", d);
        step();
        expect_val(32'h1); check("timer.int_req", {31'b0, int_req});
        mtc0(11, 32'h0000_1000, "w_compare_clr");
        rd(13, d); expect_val(32'h0); check("timer.ti_clr", {31'b0, d[30]});
        step();
        expect_val(32'h0); check("timer.int_req_clr", {31'b0, int_req});
        mtc0(12, 32'h0, "w_status_off");

        mtc0(9, 32'hFFFF_FFFF, "w_count_max");
        rd(9, d); expect_val(32'hFFFF_FFFF); check("wrap.before", d);
        step();
        step();
        rd(9, d); expect_val(32'h0); check("wrap.after", d);

        rd(9, c0);
        step();
        rd(9, c1);
        if (c1 != c0) step();
        mtc0(9, 32'd5, "w_count5");
        rd(9, d); expect_val(32'd5); check("count5.wins", d);
        step();
        rd(9, d); expect_val(32'd5); check("count5.hold", d);
        step();
        rd(9, d); expect_val(32'd6); check("count5.inc", d);

        wb_valid = 1; wb_except = 1; wb_excode = 5'h04; wb_pc = 32'h8000_9000;
        wb_badvaddr = 32'h0000_ABCD;
        rst = 1;
        #1;
        expect_val(32'h0); check("rst_exc.flush", {31'b0, flush});
        step();
        rst = 0;
        idle();
        rd(12, d); expect_val(32'h0040_0000); check("rst_exc.status", d);
        rd(14, d); expect_val(32'h0);         check("rst_exc.epc", d);
        rd(8, d);  expect_val(32'h0);         check("rst_exc.badvaddr", d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
